// File: rtl/zero_count_accum.sv
// zero_count_accum
//   Sits after the 8-bit ones-counter in the counting-zeros datapath.
//   Bytes arrive over a valid/ready handshake. For each accepted byte the
//   block adds its ones count and its zeros count (8 - ones) to running
//   frame totals. A frame ends on an accepted byte with in_last set, or on
//   the FRAME_LEN-th byte. The frame totals are then held on a second
//   valid/ready handshake until the consumer takes them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_last are valid this cycle
//   in_ready   block can accept a byte this cycle
//   in_data    byte to count
//   in_last    final byte of frame, qualified by in_valid
//   out_valid  frame totals are valid
//   out_ready  consumer accepts the totals
//   out_zeros  total zero bits in the frame
//   out_ones   total one bits in the frame
//   out_nbytes number of bytes in the frame (1..FRAME_LEN)
//
// Parameters
//   FRAME_LEN  maximum bytes per frame (>= 1)
//   CNT_W      count width; 2**CNT_W must exceed 8*FRAME_LEN

module zero_count_accum #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_zeros,
  output logic [CNT_W-1:0] out_ones,
  output logic [CNT_W-1:0] out_nbytes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ones_acc;
  logic [CNT_W-1:0] zeros_acc;
  logic [CNT_W-1:0] nbytes_acc;

  logic [3:0]       pop;
  logic [CNT_W-1:0] ones_nxt;
  logic [CNT_W-1:0] zeros_nxt;
  logic [CNT_W-1:0] nbytes_nxt;
  logic             frame_end;

  // Ones count of the incoming byte; combinational so the byte is counted
  // in the same cycle it is accepted.
  always_comb begin
    pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'b000, in_data[i]};
    end
  end

  // Totals as they would be after accepting the current byte. The 4-bit
  // counts are zero-extended; the parameter rule rules out overflow.
  assign ones_nxt   = ones_acc + CNT_W'(pop);
  assign zeros_nxt  = zeros_acc + CNT_W'(4'd8 - pop);
  assign nbytes_nxt = nbytes_acc + CNT_W'(1);
  assign frame_end  = in_last || (nbytes_nxt == CNT_W'(FRAME_LEN));

  // Handshake outputs depend on the registered state only, so there is no
  // combinational path from any input to in_ready/out_valid.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // Frame FSM and accumulators. IDLE exists only to hold in_ready low for
  // the first edge after reset. The accumulators are cleared on handoff
  // rather than on frame end, so HOLD keeps a consistent picture of the
  // frame that is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ones_acc   <= '0;
      zeros_acc  <= '0;
      nbytes_acc <= '0;
      out_zeros  <= '0;
      out_ones   <= '0;
      out_nbytes <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= ACCUM;
        end
        ACCUM: begin
          if (in_valid) begin
            ones_acc   <= ones_nxt;
            zeros_acc  <= zeros_nxt;
            nbytes_acc <= nbytes_nxt;
            if (frame_end) begin
              out_ones   <= ones_nxt;
              out_zeros  <= zeros_nxt;
              out_nbytes <= nbytes_nxt;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            ones_acc   <= '0;
            zeros_acc  <= '0;
            nbytes_acc <= '0;
            state      <= ACCUM;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_accum.sv
// tb_zero_count_accum
//   Self-checking bench for zero_count_accum. Inputs are driven and outputs
//   sampled on the falling clock edge. Expected frame totals come from a
//   reference model that sums $countones over the bytes the bench sends and
//   closes a frame on in_last or after FRAME_LEN bytes.

module tb_zero_count_accum;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_zeros;
  logic [CNT_W-1:0] out_ones;
  logic [CNT_W-1:0] out_nbytes;

  int checks;
  int errors;

  // Reference model: running frame sums and the last completed frame.
  int m_ones, m_zeros, m_n;
  int f_ones, f_zeros, f_n;

  zero_count_accum #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_zeros (out_zeros),
    .out_ones  (out_ones),
    .out_nbytes(out_nbytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    m_ones = 0; m_zeros = 0; m_n = 0;
  endtask

  // Offers one byte (called on a falling edge) and returns on the falling
  // edge after it was accepted. waits = falling edges spent with in_ready low.
  task automatic applyStimulus(input logic [7:0] d, input logic l,
                               output int waits, output bit fend);
    int c;
    waits = 0;
    fend  = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    c = $countones(d);
    m_ones  += c;
    m_zeros += 8 - c;
    m_n     += 1;
    if (l || m_n == FRAME_LEN) begin
      f_ones = m_ones; f_zeros = m_zeros; f_n = m_n;
      modelClear();
      fend = 1'b1;
    end
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_valid"},  int'(out_valid),  1);
    checkOutput({tag, "_ready"},  int'(in_ready),   0);
    checkOutput({tag, "_zeros"},  int'(out_zeros),  f_zeros);
    checkOutput({tag, "_ones"},   int'(out_ones),   f_ones);
    checkOutput({tag, "_nbytes"}, int'(out_nbytes), f_n);
  endtask

  // Holds for 'delay' cycles (totals must stay put), then hands off.
  task automatic releaseFrame(input string tag, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
      checkOutput({tag, "_hold_ones"},  int'(out_ones),  f_ones);
      checkOutput({tag, "_hold_n"},     int'(out_nbytes), f_n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_rel_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_rel_ready"}, int'(in_ready),  1);
    checkOutput({tag, "_rel_zeros"}, int'(out_zeros), f_zeros);
  endtask

  // Asynchronous reset pulse between clock edges; everything must clear at
  // once, and in_ready must return only after the first edge.
  task automatic resetPulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_ready"},  int'(in_ready),   0);
    checkOutput({tag, "_valid"},  int'(out_valid),  0);
    checkOutput({tag, "_zeros"},  int'(out_zeros),  0);
    checkOutput({tag, "_ones"},   int'(out_ones),   0);
    checkOutput({tag, "_nbytes"}, int'(out_nbytes), 0);
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput({tag, "_ready_rel"}, int'(in_ready), 0);
    @(negedge clk);
    checkOutput({tag, "_ready_edge1"}, int'(in_ready), 1);
  endtask

  initial begin
    int  w;
    bit  fe;
    int  len;
    bit  uselast;
    logic [7:0] b;

    checks = 0; errors = 0;
    modelClear();
    f_ones = 0; f_zeros = 0; f_n = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    out_ready = 1'b0;

    // Power-on reset.
    repeat (3) @(negedge clk);
    checkOutput("por_ready",  int'(in_ready),   0);
    checkOutput("por_valid",  int'(out_valid),  0);
    checkOutput("por_zeros",  int'(out_zeros),  0);
    checkOutput("por_ones",   int'(out_ones),   0);
    checkOutput("por_nbytes", int'(out_nbytes), 0);
    rst_n = 1'b1;
    checkOutput("por_ready_rel", int'(in_ready), 0);
    @(negedge clk);
    checkOutput("por_ready_edge1", int'(in_ready), 1);

    // Reset mid-frame: the two partial bytes must be forgotten.
    applyStimulus(8'hFF, 1'b0, w, fe);
    applyStimulus(8'hFF, 1'b0, w, fe);
    resetPulse("rst_midframe");

    // Early end on in_last.
    applyStimulus(8'hFF, 1'b0, w, fe);
    applyStimulus(8'h0F, 1'b0, w, fe);
    applyStimulus(8'h01, 1'b1, w, fe);
    checkOutput("early_fend", int'(fe), 1);
    checkFrame("early");
    checkOutput("early_zeros_const",  int'(out_zeros),  11);
    checkOutput("early_ones_const",   int'(out_ones),   13);
    checkOutput("early_nbytes_const", int'(out_nbytes), 3);
    releaseFrame("early", 2);

    // Full frame of zero bytes, no in_last.
    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(8'h00, 1'b0, w, fe);
      if (i == FRAME_LEN - 2) checkOutput("full_not_yet", int'(out_valid), 0);
    end
    checkFrame("full");
    checkOutput("full_zeros_const", int'(out_zeros), 128);
    checkOutput("full_ones_const",  int'(out_ones),  0);

    // Backpressure: offer 0xAA for 5 held cycles; nothing may be taken.
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_ready", int'(in_ready),  0);
      checkOutput("bp_zeros", int'(out_zeros), 128);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_rel_valid", int'(out_valid), 0);
    applyStimulus(8'hAA, 1'b1, w, fe);
    checkFrame("bp_next");
    checkOutput("bp_next_nbytes_const", int'(out_nbytes), 1);

    // Reset while holding totals.
    resetPulse("rst_midhold");

    // Gaps between bytes.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(8'h80, (i == 3), w, fe);
    end
    checkFrame("gaps");
    checkOutput("gaps_zeros_const", int'(out_zeros), 28);
    releaseFrame("gaps", $urandom_range(0, 3));

    // Randomised frames: random length (some longer than FRAME_LEN so the
    // length limit closes them), random data, gaps and consumer delay.
    for (int f = 0; f < 12; f++) begin
      len     = $urandom_range(1, FRAME_LEN + 4);
      uselast = $urandom_range(0, 1);
      fe      = 1'b0;
      for (int i = 0; i < len && !fe; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        // Stray in_last with in_valid low must be ignored.
        in_last = 1'b1;
        b = 8'($urandom);
        applyStimulus(b, uselast && (i == len - 1), w, fe);
      end
      if (!fe) begin
        // Frame still open without in_last: close it with one more byte.
        applyStimulus(8'($urandom), 1'b1, w, fe);
      end
      checkFrame("rand");
      releaseFrame("rand", $urandom_range(0, 3));
    end

    // Back-to-back frames with out_ready tied high: one bubble per frame.
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        applyStimulus((f == 0) ? 8'hFF : 8'h55, 1'b0, w, fe);
        if (f == 1 && i == 0) checkOutput("b2b_bubble", w, 1);
        else if (f == 1)      checkOutput("b2b_nowait", w, 0);
      end
      checkFrame("b2b");
      checkOutput("b2b_zeros_const", int'(out_zeros), (f == 0) ? 0 : 64);
      checkOutput("b2b_ones_const",  int'(out_ones),  (f == 0) ? 128 : 64);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("b2b_end_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
